// File: rtl/sb_1237_uart_pkg.sv
// Shared state encoding and width defaults for the UART message scheduler.
package sb_1237_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } sched_st_t;

  localparam int DEF_MSG_W     = 128;
  localparam int DEF_LEN_W     = 8;
  localparam int MSG_MAX_BYTES = DEF_MSG_W / 8;

endpackage

// File: rtl/sb_1237_rr_arb.sv
// Round-robin pick among pending slots, searching from the index after `last`; purely combinational.
// Zero latency; no backpressure, the caller advances `last` only when it takes the grant.
module sb_1237_rr_arb #(
  parameter int N_REQ = 3,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IW-1:0]    last,
  output logic             gnt_vld,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  always_comb begin
    logic [IW-1:0] idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!gnt_vld && pending[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sb_1237_uart_msg_sched.sv
// Shares one UART transmitter between N_REQ one-entry message slots, served round-robin; launch 2 cycles after post.
// Posts to a busy slot or with a bad length are dropped (sticky drop_err); a launch waits for done or timeout.
module sb_1237_uart_msg_sched
  import sb_1237_uart_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MSG_W       = DEF_MSG_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int GAP_CYC     = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MSG_W-1:0] req_msg,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       pending,
  output logic [N_REQ-1:0]       sent,
  output logic [N_REQ-1:0]       timeout,
  output logic [N_REQ-1:0]       drop_err,
  output logic                   uart_transmit,
  output logic [MSG_W-1:0]       uart_str,
  output logic [LEN_W-1:0]       uart_len,
  input  logic                   uart_done
);

  localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW        = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int MAX_BYTES = MSG_W / 8;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);

  sched_st_t state, state_nxt;

  logic [MSG_W-1:0] slot_msg [N_REQ];
  logic [LEN_W-1:0] slot_len [N_REQ];

  logic [IW-1:0]    last;
  logic [N_REQ-1:0] cur_oh;
  logic [TW-1:0]    tcnt;
  logic [GW-1:0]    gcnt;

  logic             arb_vld;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;

  logic             take, launch, fin_ok, fin_to;
  logic [N_REQ-1:0] pend_clr, accept;

  sb_1237_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .pending (pending),
    .last    (last),
    .gnt_vld (arb_vld),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    launch    = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          take      = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        launch    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (uart_done) begin
          fin_ok    = 1'b1;
          state_nxt = GAP;
        end else if (tcnt == TO_LAST) begin
          fin_to    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The finishing slot is released before new posts are judged, so a repost in that cycle is taken.
  always_comb begin
    logic [LEN_W-1:0] ln;
    ln       = '0;
    pend_clr = pending & ~(cur_oh & {N_REQ{fin_ok | fin_to}});
    accept   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ln        = req_len[i*LEN_W +: LEN_W];
      accept[i] = req[i] && !pend_clr[i] && (ln != '0) && (int'(ln) <= MAX_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      sent          <= '0;
      timeout       <= '0;
      drop_err      <= '0;
      uart_transmit <= 1'b0;
      uart_str      <= '0;
      uart_len      <= '0;
      last          <= IW'(N_REQ - 1);
      cur_oh        <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
    end else begin
      pending       <= pend_clr | accept;
      drop_err      <= drop_err | (req & ~accept);
      sent          <= cur_oh & {N_REQ{fin_ok}};
      timeout       <= cur_oh & {N_REQ{fin_to}};
      uart_transmit <= launch;
      if (take) begin
        last     <= arb_idx;
        cur_oh   <= arb_gnt;
        uart_str <= slot_msg[arb_idx];
        uart_len <= slot_len[arb_idx];
      end
      if (launch) begin
        tcnt <= '0;
      end else if (state == WAIT && tcnt != TO_LAST) begin
        tcnt <= tcnt + 1'b1;
      end
      if (state != GAP) begin
        gcnt <= '0;
      end else if (gcnt != GAP_LAST) begin
        gcnt <= gcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_msg[i] <= '0;
        slot_len[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          slot_msg[i] <= req_msg[i*MSG_W +: MSG_W];
          slot_len[i] <= req_len[i*LEN_W +: LEN_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_1237_uart_msg_sched.sv
// Directed bench for the UART message scheduler: posting, round-robin, drops, timeout, collision, reset.
module tb_sb_1237_uart_msg_sched;

  localparam int N   = 3;
  localparam int MW  = 128;
  localparam int LW  = 8;
  localparam int TO  = 1000;
  localparam int GAP = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req;
  logic [N*MW-1:0] req_msg;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    pending, sent, timeout, drop_err;
  logic            uart_transmit;
  logic [MW-1:0]   uart_str;
  logic [LW-1:0]   uart_len;
  logic            uart_done;

  int checks = 0;
  int errors = 0;

  sb_1237_uart_msg_sched #(
    .N_REQ       (N),
    .MSG_W       (MW),
    .LEN_W       (LW),
    .TIMEOUT_CYC (TO),
    .GAP_CYC     (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_msg       (req_msg),
    .req_len       (req_len),
    .pending       (pending),
    .sent          (sent),
    .timeout       (timeout),
    .drop_err      (drop_err),
    .uart_transmit (uart_transmit),
    .uart_str      (uart_str),
    .uart_len      (uart_len),
    .uart_done     (uart_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [127:0] m, input logic [7:0] l);
    req_msg[i*MW +: MW] = m;
    req_len[i*LW +: LW] = l;
  endtask

  task automatic post(input logic [N-1:0] mask);
    req = mask;
    tick();
    req = '0;
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    while (uart_transmit !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_tx(input int d);
    repeat (d) tick();
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
  endtask

  function automatic logic [127:0] rr_msg(input int i);
    return {"RR-SRC-", 8'(48 + i), 64'h0};
  endfunction

  task automatic rr_round(input int o0, input int o1, input int o2);
    int ord [3];
    int n;
    ord[0] = o0;
    ord[1] = o1;
    ord[2] = o2;
    for (int i = 0; i < N; i++) set_src(i, rr_msg(i), 8'(i + 1));
    post(3'b111);
    chk("rr_pending", pending, 3'b111);
    for (int k = 0; k < 3; k++) begin
      wait_tx(n);
      chk("rr_latency", n, (k == 0) ? 2 : GAP + 2);
      chk("rr_len", uart_len, ord[k] + 1);
      chk("rr_str", uart_str, rr_msg(ord[k]));
      finish_tx(50);
      chk("rr_sent", sent, 1 << ord[k]);
    end
    repeat (GAP + 2) tick();
  endtask

  initial begin
    logic [127:0] m_gbi, m0, ma, mb, mc, t1, t2, md;
    int n, cnt;
    m_gbi = {"GBI3-W-#", 64'h0};
    m0    = {"DROPTST0", 64'h0};
    ma    = {"AAAA", 96'h0};
    mb    = {"BBBBB", 88'h0};
    mc    = 128'h0123456789ABCDEF_FEDCBA9876543210;
    t1    = {"TMO1", 96'h0};
    t2    = {"TMO2", 96'h0};
    md    = {"REPST", 88'h0};
    req = '0;
    req_msg = '0;
    req_len = '0;
    uart_done = 1'b0;

    #12;
    chk("rst_pending", pending, 0);
    chk("rst_sent", sent, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_tx", uart_transmit, 0);
    chk("rst_str", uart_str, 0);
    chk("rst_len", uart_len, 0);
    rst_n = 1'b1;
    tick();

    // round-robin from reset pointer
    rr_round(0, 1, 2);

    // single post, launch 2 cycles after the sampling edge
    set_src(0, m_gbi, 8);
    post(3'b001);
    chk("single_pending", pending, 3'b001);
    wait_tx(n);
    chk("single_latency", n, 2);
    chk("single_len", uart_len, 8);
    chk("single_str", uart_str, m_gbi);
    tick();
    chk("single_tx_pulse", uart_transmit, 0);
    finish_tx(99);
    chk("single_sent", sent, 3'b001);
    chk("single_clear", pending, 3'b000);
    tick();
    chk("single_sent_pulse", sent, 3'b000);
    repeat (GAP + 2) tick();

    // round-robin with last grant = 0
    rr_round(1, 2, 0);

    // drops: busy slot, length 0, length 17; length 16 accepted
    set_src(0, m0, 8);
    post(3'b001);
    wait_tx(n);
    chk("drop_launch", n, 2);
    set_src(1, ma, 4);
    post(3'b010);
    chk("drop_pend1", pending, 3'b011);
    chk("drop_none", drop_err, 3'b000);
    set_src(1, mb, 5);
    post(3'b010);
    chk("drop_busy", drop_err, 3'b010);
    chk("drop_busy_pend", pending, 3'b011);
    set_src(2, mc, 0);
    post(3'b100);
    chk("drop_len0", drop_err, 3'b110);
    chk("drop_len0_pend", pending, 3'b011);
    set_src(2, mc, 17);
    post(3'b100);
    chk("drop_len17_pend", pending, 3'b011);
    set_src(2, mc, 16);
    post(3'b100);
    chk("len16_accept", pending, 3'b111);
    finish_tx(20);
    chk("drop_sent0", sent, 3'b001);
    wait_tx(n);
    chk("drop_gap", n, GAP + 2);
    chk("drop_keep_str", uart_str, ma);
    chk("drop_keep_len", uart_len, 4);
    finish_tx(10);
    wait_tx(n);
    chk("len16_str", uart_str, mc);
    chk("len16_len", uart_len, 16);
    finish_tx(10);
    chk("len16_sent", sent, 3'b100);
    chk("drop_sticky", drop_err, 3'b110);
    repeat (GAP + 2) tick();

    // timeout on slot 1, then slot 2 served after the gap
    set_src(1, t1, 2);
    set_src(2, t2, 3);
    post(3'b110);
    wait_tx(n);
    chk("to_launch", n, 2);
    chk("to_first_len", uart_len, 2);
    n = 0;
    while (timeout[1] !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("to_latency", n, TO);
    chk("to_no_sent", sent, 3'b000);
    chk("to_pending", pending, 3'b100);
    tick();
    chk("to_pulse", timeout, 3'b000);
    wait_tx(n);
    chk("to_next_gap", n, GAP + 1);
    chk("to_next_len", uart_len, 3);
    chk("to_next_str", uart_str, t2);

    // done on the timeout cycle, with a repost of the same slot
    repeat (TO - 1) tick();
    uart_done = 1'b1;
    set_src(2, md, 5);
    req = 3'b100;
    tick();
    uart_done = 1'b0;
    req = '0;
    chk("coll_sent", sent, 3'b100);
    chk("coll_no_to", timeout, 3'b000);
    chk("repost_pending", pending, 3'b100);
    tick();
    chk("coll_no_to_late", timeout, 3'b000);
    wait_tx(n);
    chk("repost_gap", n, GAP + 1);
    chk("repost_len", uart_len, 5);
    chk("repost_str", uart_str, md);
    finish_tx(5);
    chk("repost_sent", sent, 3'b100);
    chk("repost_clear", pending, 3'b000);
    repeat (GAP + 2) tick();

    // reset in the middle of WAIT
    set_src(0, m0, 8);
    post(3'b001);
    wait_tx(n);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_drop", drop_err, 0);
    chk("mid_rst_str", uart_str, 0);
    chk("mid_rst_len", uart_len, 0);
    chk("mid_rst_tx", uart_transmit, 0);
    #1;
    rst_n = 1'b1;
    tick();
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    chk("stray_done_sent", sent, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uart_transmit === 1'b1 || pending !== 3'b000) cnt++;
    end
    chk("stray_done_idle", cnt, 0);
    post(3'b111);
    wait_tx(n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_first", uart_len, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
